bcd_seg_scanner: RTL and testbench

Consumer end of the 4-digit BCD bus (BCD3..BCD0, 4'hF per digit = overflow) produced by the trigger/counter blocks. Time-multiplexes the four digits onto a common-anode 7-segment display: one digit slot at a time, with an inter-digit ghosting blank, optional leading-zero blanking, and a once-per-frame snapshot of the inputs so the display never tears.

---
 rtl/bcd_seg_scanner.sv | 197 +++++++++++++++++++
 tb/tb_bcd_seg_scanner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner
// ---------------
// Time-multiplexes a 4-digit BCD value onto a common-anode 7-segment display.
//
// Each digit owns a slot of REFRESH_DIV clock cycles. The first BLANK_CYC
// cycles of every slot turn all anodes off so the previous digit's segment
// pattern cannot ghost onto the next digit. The four BCD inputs are sampled
// together once per frame (end of the digit-3 slot), so a value that changes
// mid-frame never produces a torn display. Leading zeros on digits 3..1 can
// optionally be blanked. A digit value of 4'hF is shown as a dash (overflow).
// Values 4'hA..4'hE are shown blank.
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   BCD0..3    in   units .. thousands digits (4'hF = overflow)
//   An[3:0]    out  digit anodes, active-low, An[i] drives digit i
//   Seg[6:0]   out  segments {g,f,e,d,c,b,a}, active-low
//   FrameTick  out  one-cycle pulse in the cycle after a new snapshot
//
// All outputs are registered: each edge loads the decode of the pre-edge
// (div, idx, snapshot) state, giving one cycle of latency to the pins.

module bcd_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1,
  parameter int LZ_BLANK    = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] BCD0,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD3,
  output logic [3:0] An,
  output logic [6:0] Seg,
  output logic       FrameTick
);

  localparam int            DW      = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // BCD digit to active-low segment pattern; unused codes A..E stay dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h10;
      4'hF:    pattern = 7'h3F;
      default: pattern = 7'h7F;
    endcase
    return pattern;
  endfunction

  // State
  logic [DW-1:0] r_div;
  logic [1:0]    r_idx;
  logic [3:0]    r_snap0;
  logic [3:0]    r_snap1;
  logic [3:0]    r_snap2;
  logic [3:0]    r_snap3;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_frame_tick;

  // Combinational next-state / output decode
  logic          w_div_wrap;
  logic          w_capture;
  logic          w_blank;
  logic [DW-1:0] w_div_nxt;
  logic [1:0]    w_idx_nxt;
  logic [3:0]    w_digit;
  logic          w_digit_lz;
  logic [3:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;
  logic          w_z3;
  logic          w_z32;
  logic          w_z321;
  logic [3:0]    w_lz_mask;

  assign w_div_wrap = (r_div == DIV_MAX);
  // Snapshot is taken on the final edge of the digit-3 slot, i.e. at the
  // frame boundary, so a whole frame always shows one coherent value.
  assign w_capture  = w_div_wrap && (r_idx == 2'd3);

  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign w_blank = 1'b0;
    end else begin : g_blank
      assign w_blank = (r_div < DW'(BLANK_CYC));
    end
  endgenerate

  // Leading-zero chain: a digit is blanked only if it and every higher digit
  // are zero. 4'hF counts as nonzero, so overflow still shows all dashes.
  assign w_z3   = (r_snap3 == 4'd0);
  assign w_z32  = w_z3  && (r_snap2 == 4'd0);
  assign w_z321 = w_z32 && (r_snap1 == 4'd0);
  assign w_lz_mask = (LZ_BLANK != 0) ? {w_z3, w_z32, w_z321, 1'b0} : 4'b0000;

  // Divider / slot index advance
  always_comb begin
    w_div_nxt = r_div + {{(DW-1){1'b0}}, 1'b1};
    w_idx_nxt = r_idx;
    if (w_div_wrap) begin
      w_div_nxt = {DW{1'b0}};
      w_idx_nxt = r_idx + 2'd1;
    end else begin
      w_idx_nxt = r_idx;
    end
  end

  // Select the snapshot digit for the current slot and its blanking flag
  always_comb begin
    w_digit    = r_snap0;
    w_digit_lz = 1'b0;
    case (r_idx)
      2'd0:    begin w_digit = r_snap0; w_digit_lz = w_lz_mask[0]; end
      2'd1:    begin w_digit = r_snap1; w_digit_lz = w_lz_mask[1]; end
      2'd2:    begin w_digit = r_snap2; w_digit_lz = w_lz_mask[2]; end
      2'd3:    begin w_digit = r_snap3; w_digit_lz = w_lz_mask[3]; end
      default: begin w_digit = r_snap0; w_digit_lz = 1'b0;         end
    endcase
  end

  // Pin values for the next cycle from the current (pre-edge) state
  always_comb begin
    w_an_nxt  = AN_OFF;
    w_seg_nxt = SEG_OFF;
    if (w_blank) begin
      w_an_nxt  = AN_OFF;
      w_seg_nxt = SEG_OFF;
    end else begin
      w_an_nxt  = ~(4'b0001 << r_idx);
      if (w_digit_lz) begin
        w_seg_nxt = SEG_OFF;
      end else begin
        w_seg_nxt = seg_decode(w_digit);
      end
    end
  end

  // Scan counters
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_div <= {DW{1'b0}};
      r_idx <= 2'd0;
    end else begin
      r_div <= w_div_nxt;
      r_idx <= w_idx_nxt;
    end
  end

  // Once-per-frame input snapshot
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_snap0 <= 4'd0;
      r_snap1 <= 4'd0;
      r_snap2 <= 4'd0;
      r_snap3 <= 4'd0;
    end else if (w_capture) begin
      r_snap0 <= BCD0;
      r_snap1 <= BCD1;
      r_snap2 <= BCD2;
      r_snap3 <= BCD3;
    end
  end

  // Registered outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_an         <= AN_OFF;
      r_seg        <= SEG_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_frame_tick <= w_capture;
    end
  end

  assign An        = r_an;
  assign Seg       = r_seg;
  assign FrameTick = r_frame_tick;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Testbench for bcd_seg_scanner (REFRESH_DIV=4, BLANK_CYC=1).
// Two instances share all inputs: one with leading-zero blanking, one without.
// A cycle-count based reference model predicts every output on every cycle.

module tb_bcd_seg_scanner;

  localparam int R     = 4;
  localparam int B     = 1;
  localparam int FRAME = 4 * R;

  logic       Clk;
  logic       Reset;
  logic [3:0] bcd [4];

  logic [3:0] an1, an0;
  logic [6:0] seg1, seg0;
  logic       tick1, tick0;

  int n_checks;
  int n_fail;

  // Reference model state: edges since reset release, and held snapshot
  int         m_cnt;
  logic [3:0] m_snap [4];
  logic       m_last_tick;

  bcd_seg_scanner #(.REFRESH_DIV(R), .BLANK_CYC(B), .LZ_BLANK(1)) dut_lz (
    .Clk(Clk), .Reset(Reset),
    .BCD0(bcd[0]), .BCD1(bcd[1]), .BCD2(bcd[2]), .BCD3(bcd[3]),
    .An(an1), .Seg(seg1), .FrameTick(tick1)
  );

  bcd_seg_scanner #(.REFRESH_DIV(R), .BLANK_CYC(B), .LZ_BLANK(0)) dut_nlz (
    .Clk(Clk), .Reset(Reset),
    .BCD0(bcd[0]), .BCD1(bcd[1]), .BCD2(bcd[2]), .BCD3(bcd[3]),
    .An(an0), .Seg(seg0), .FrameTick(tick0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] v);
    logic [6:0] lut [16];
    lut[0] = 7'h40; lut[1] = 7'h79; lut[2] = 7'h24; lut[3] = 7'h30;
    lut[4] = 7'h19; lut[5] = 7'h12; lut[6] = 7'h02; lut[7] = 7'h78;
    lut[8] = 7'h00; lut[9] = 7'h10;
    for (int i = 10; i < 15; i++) lut[i] = 7'h7F;
    lut[15] = 7'h3F;
    return lut[v];
  endfunction

  // Digit k shows blank under LZ rule if it and all digits above are zero.
  function automatic logic [6:0] ref_seg(input int k, input logic lz);
    logic all_zero;
    all_zero = 1'b1;
    for (int j = k; j < 4; j++) if (m_snap[j] != 4'd0) all_zero = 1'b0;
    if (lz && k > 0 && all_zero) return 7'h7F;
    return ref_glyph(m_snap[k]);
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
    m_last_tick = 1'b0;
  endtask

  // One clock: predict, clock, update model, compare at the falling edge.
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_s1, e_s0;
    logic       e_tick;
    int         div, idx;
    e_an = 4'hF; e_s1 = 7'h7F; e_s0 = 7'h7F; e_tick = 1'b0;
    div = m_cnt % R;
    idx = (m_cnt / R) % 4;
    if (Reset) begin
      if (div >= B) begin
        e_an[idx] = 1'b0;
        e_s1 = ref_seg(idx, 1'b1);
        e_s0 = ref_seg(idx, 1'b0);
      end
      e_tick = (div == R - 1) && (idx == 3);
    end
    @(posedge Clk);
    if (Reset) begin
      if (e_tick) for (int i = 0; i < 4; i++) m_snap[i] = bcd[i];
      m_cnt++;
    end
    m_last_tick = e_tick;
    @(negedge Clk);
    chk("an_lz",    {28'd0, an1},  {28'd0, e_an});
    chk("seg_lz",   {25'd0, seg1}, {25'd0, e_s1});
    chk("tick_lz",  {31'd0, tick1}, {31'd0, e_tick});
    chk("an_nlz",   {28'd0, an0},  {28'd0, e_an});
    chk("seg_nlz",  {25'd0, seg0}, {25'd0, e_s0});
    chk("tick_nlz", {31'd0, tick0}, {31'd0, e_tick});
  endtask

  // Run until the next snapshot, then record the mid-slot segments of a frame.
  task automatic run_frame(output logic [27:0] s1, output logic [27:0] s0);
    int guard;
    int pre;
    guard = 0;
    s1 = '0; s0 = '0;
    do begin
      step();
      guard++;
    end while (!m_last_tick && guard < 3 * FRAME);
    chk("frame_timeout", {31'd0, m_last_tick}, 32'd1);
    for (int c = 0; c < FRAME; c++) begin
      pre = m_cnt;
      step();
      if (pre % R == 2) begin
        s1[((pre / R) % 4) * 7 +: 7] = seg1;
        s0[((pre / R) % 4) * 7 +: 7] = seg0;
      end
    end
  endtask

  typedef struct packed {
    logic [15:0] d;   // {d3,d2,d1,d0}
    logic [27:0] e1;  // {slot3..slot0} with LZ blanking
    logic [27:0] e0;  // {slot3..slot0} without LZ blanking
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [27:0] s1, s0;
    int n;

    vecs[0] = '{16'h4321, {7'h19,7'h30,7'h24,7'h79}, {7'h19,7'h30,7'h24,7'h79}};
    vecs[1] = '{16'h0050, {7'h7F,7'h7F,7'h12,7'h40}, {7'h40,7'h40,7'h12,7'h40}};
    vecs[2] = '{16'hFFFF, {7'h3F,7'h3F,7'h3F,7'h3F}, {7'h3F,7'h3F,7'h3F,7'h3F}};
    vecs[3] = '{16'h000B, {7'h7F,7'h7F,7'h7F,7'h7F}, {7'h40,7'h40,7'h40,7'h7F}};
    vecs[4] = '{16'h0000, {7'h7F,7'h7F,7'h7F,7'h40}, {7'h40,7'h40,7'h40,7'h40}};
    vecs[5] = '{16'h9876, {7'h10,7'h00,7'h78,7'h02}, {7'h10,7'h00,7'h78,7'h02}};
    vecs[6] = '{16'h0F00, {7'h7F,7'h3F,7'h40,7'h40}, {7'h40,7'h3F,7'h40,7'h40}};
    vecs[7] = '{16'h0A10, {7'h7F,7'h7F,7'h79,7'h40}, {7'h40,7'h7F,7'h79,7'h40}};

    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    for (int i = 0; i < 4; i++) bcd[i] = 4'd0;
    model_reset();

    // Asynchronous reset between clock edges
    #2 Reset = 1'b0;
    #1;
    chk("rst_an",   {28'd0, an1},  32'hF);
    chk("rst_seg",  {25'd0, seg1}, 32'h7F);
    chk("rst_tick", {31'd0, tick1}, 32'd0);
    for (int c = 0; c < 10; c++) step();

    // Release with 4,3,2,1: first frame shows reset snapshot
    bcd[3] = 4'd4; bcd[2] = 4'd3; bcd[1] = 4'd2; bcd[0] = 4'd1;
    Reset = 1'b1;
    for (int c = 1; c <= FRAME; c++) begin
      step();
      if (c == 1) chk("first_blank", {28'd0, an1}, 32'hF);
      if (c == 2) begin
        chk("first_an0", {28'd0, an1}, 32'hE);
        chk("first_seg0", {25'd0, seg1}, 32'h40);
      end
      if (c == 15) chk("first_d3_dark", {25'd0, seg1}, 32'h7F);
    end
    chk("tick_cycle16", {31'd0, tick1}, 32'd1);
    for (int c = 0; c < FRAME; c++) begin
      step();
      if (c == 2)  chk("f2_seg0", {25'd0, seg1}, 32'h79);
      if (c == 14) begin
        chk("f2_an3", {28'd0, an1}, 32'h7);
        chk("f2_seg3", {25'd0, seg1}, 32'h19);
      end
    end

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 4; i++) bcd[i] = vecs[v].d[i*4 +: 4];
      run_frame(s1, s0);
      chk($sformatf("tbl%0d_lz", v),  {4'd0, s1}, {4'd0, vecs[v].e1});
      chk($sformatf("tbl%0d_nlz", v), {4'd0, s0}, {4'd0, vecs[v].e0});
    end

    // Tear-free: digit0 changes 1->7 during the idx=2 slot
    bcd[3] = 4'd0; bcd[2] = 4'd0; bcd[1] = 4'd0; bcd[0] = 4'd1;
    run_frame(s1, s0);
    chk("tear_before", {25'd0, s1[6:0]}, 32'h79);
    while ((m_cnt % FRAME) != 2 * R + 1) step();
    bcd[0] = 4'd7;
    while ((m_cnt % FRAME) != 0) step();
    n = 0;
    do begin step(); n++; end while (!m_last_tick && n < 2 * FRAME);
    chk("tear_tick", {31'd0, m_last_tick}, 32'd1);
    for (int c = 0; c < 3; c++) step();
    chk("tear_after", {25'd0, seg1}, 32'h78);

    // Reset mid-scan at idx=2, div=2
    bcd[3] = 4'd4; bcd[2] = 4'd3; bcd[1] = 4'd2; bcd[0] = 4'd1;
    run_frame(s1, s0);
    while ((m_cnt % FRAME) != 2 * R + 2) step();
    chk("mid_active", {28'd0, an1}, 32'hB);
    Reset = 1'b0;
    #1;
    chk("mid_rst_an", {28'd0, an1}, 32'hF);
    chk("mid_rst_seg", {25'd0, seg1}, 32'h7F);
    model_reset();
    for (int c = 0; c < 3; c++) step();
    Reset = 1'b1;
    step();
    step();
    chk("mid_rel_an", {28'd0, an1}, 32'hE);
    chk("mid_rel_seg", {25'd0, seg1}, 32'h40);

    // Randomized run against the model, with occasional resets
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(0, 3);
        bcd[n] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 199) == 0) begin
        Reset = 1'b0;
        model_reset();
      end else begin
        Reset = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
